// File: rtl/router_pkg.sv
// router_pkg: shared types and defaults for the router controller.
// Holds the FSM state enum, the destination address type, the default
// soft-reset timeout, and a helper that decodes an address to a one-hot port.
package router_pkg;
  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_e;
  typedef logic [1:0] addr_t;
  localparam int SOFT_RST_CYCLES_DEF = 30;
  // Address 3 is not a port and decodes to no port.
  function automatic logic [2:0] port_sel(addr_t a);
    return 3'b001 << a;
  endfunction
endpackage

// File: rtl/router_sreset_timer.sv
// router_sreset_timer: per-port unread-data watchdog (present only with ROUTER_SOFT_RST_EN).
// Ports: clk, reset (async active-low); fifo_empty, read_enb for one output port;
// soft_reset pulses for one cycle after CYCLES consecutive unread cycles.
`ifdef ROUTER_SOFT_RST_EN
module router_sreset_timer #(
  parameter int CYCLES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic fifo_empty,
  input  logic read_enb,
  output logic soft_reset
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic sr_q, sr_d, idle;
  always_comb begin
    idle = !fifo_empty && !read_enb;
    sr_d = idle && cnt_q == W'(CYCLES - 1);
    cnt_d = (!idle || sr_d) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q <= sr_d;
    end
  end
  assign soft_reset = sr_q;
endmodule
`endif

// File: rtl/router_ctrl.sv
// router_ctrl: packet router write-side controller (Moore FSM).
// Ports: clk, reset (async active-low); pkt_valid, data_in from the source;
// fifo_full/fifo_empty/read_enb per output FIFO; parity_done, low_pkt_valid from
// the register block; busy, write_enb, state strobes, valid_out, soft_reset out.
// Macro ROUTER_SOFT_RST_EN adds per-port soft-reset timers; otherwise soft_reset is 0.
module router_ctrl
  import router_pkg::*;
#(
  parameter int SOFT_RST_CYCLES = SOFT_RST_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic [2:0] valid_out,
  output logic [2:0] soft_reset
);
  state_e state_q, state_d;
  addr_t addr_q, addr_d;
  addr_t hdr_addr;
  logic unused_ok;
  assign hdr_addr = data_in[1:0];
  assign unused_ok = ^{data_in[7:2], read_enb} ^ (SOFT_RST_CYCLES == 0);
`ifdef ROUTER_SOFT_RST_EN
  for (genvar i = 0; i < 3; i++) begin : g_sr
    router_sreset_timer #(.CYCLES(SOFT_RST_CYCLES)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .fifo_empty(fifo_empty[i]),
      .read_enb  (read_enb[i]),
      .soft_reset(soft_reset[i])
    );
  end
`else
  assign soft_reset = '0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    case (state_q)
      DECODE_ADDRESS:
        if (pkt_valid && hdr_addr != 2'd3) begin
          addr_d = hdr_addr;
          state_d = fifo_empty[hdr_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      WAIT_TILL_EMPTY:    state_d = fifo_empty[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA:          state_d = fifo_full[addr_q] ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    state_d = fifo_full[addr_q] ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    state_d = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
    // A flush of the port being written abandons the packet from any state.
    if (soft_reset[addr_q] && state_q != DECODE_ADDRESS) state_d = DECODE_ADDRESS;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
    end
  end
  always_comb begin
    detect_add = state_q == DECODE_ADDRESS;
    lfd_state = state_q == LOAD_FIRST_DATA;
    ld_state = state_q == LOAD_DATA;
    laf_state = state_q == LOAD_AFTER_FULL;
    full_state = state_q == FIFO_FULL_STATE;
    rst_int_reg = state_q == CHECK_PARITY_ERROR;
    busy = !(detect_add || ld_state);
    write_enb = (lfd_state || ld_state || laf_state || state_q == LOAD_PARITY) ? port_sel(addr_q) : 3'b000;
    valid_out = ~fifo_empty;
  end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed scoreboard bench for router_ctrl.
module tb_router_ctrl;
  import router_pkg::*;
  logic clk = 1'b0, reset = 1'b0, pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] fifo_full = '0, fifo_empty = 3'b111, read_enb = '0;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [2:0] write_enb, valid_out, soft_reset;
  logic [15:0] act;
  typedef struct { string name; logic [15:0] v; } exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0, errors = 0;
  localparam logic [2:0] RST = 3'b000, RUN = 3'b100, PD = 3'b110, LPV = 3'b101;

  router_ctrl dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .busy(busy),
    .write_enb(write_enb), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .valid_out(valid_out), .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  assign act = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb, soft_reset, valid_out};

  // Expected Moore outputs for a state, from the state/strobe table.
  function automatic logic [15:0] model(state_e s, addr_t a, logic [2:0] sr, logic [2:0] fe);
    logic b;
    logic [2:0] we;
    b = !(s == DECODE_ADDRESS || s == LOAD_DATA);
    we = (s == LOAD_FIRST_DATA || s == LOAD_DATA || s == LOAD_AFTER_FULL || s == LOAD_PARITY) ? (3'b001 << a) : 3'b000;
    return {b, s == DECODE_ADDRESS, s == LOAD_FIRST_DATA, s == LOAD_DATA, s == LOAD_AFTER_FULL,
            s == FIFO_FULL_STATE, s == CHECK_PARITY_ERROR, we, sr, ~fe};
  endfunction

  // One cycle: drive inputs just after the edge, expect outputs of state s for that cycle.
  task automatic cyc(input string nm, input logic [2:0] ctl, input logic pv, input logic [7:0] d,
                     input logic [2:0] ff, input logic [2:0] fe, input logic [2:0] re,
                     input state_e s, input addr_t a, input logic [2:0] sr);
    @(posedge clk);
    #1;
    {reset, parity_done, low_pkt_valid} = ctl;
    pkt_valid = pv;
    data_in = d;
    fifo_full = ff;
    fifo_empty = fe;
    read_enb = re;
    q.push_back('{nm, model(s, a, sr, fe)});
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      checks++;
      if (act !== cur.v) begin
        errors++;
        $display("FAIL %s got %h want %h", cur.name, act, cur.v);
      end
    end
  end

  initial begin
    cyc("rst", RST, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("rst_hold", RST, 1, 8'h05, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("hdr1", RUN, 1, 8'h05, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("lfd1", RUN, 1, 8'h11, 0, 3'b111, 0, LOAD_FIRST_DATA, 1, 0);
    for (int i = 0; i < 5; i++) cyc("ld1", RUN, i < 4, 8'h20 + 8'(i), 0, 3'b111, 0, LOAD_DATA, 1, 0);
    cyc("lp1", RUN, 0, 8'hAA, 0, 3'b111, 0, LOAD_PARITY, 1, 0);
    cyc("chk1", RUN, 0, 8'h00, 0, 3'b111, 0, CHECK_PARITY_ERROR, 1, 0);
    cyc("idle1", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
    cyc("hdr3", RUN, 1, 8'h03, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
    cyc("drop3", RUN, 1, 8'h03, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
    cyc("drop3b", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
    cyc("hdr2", RUN, 1, 8'h06, 0, 3'b011, 0, DECODE_ADDRESS, 1, 0);
    cyc("wait2a", RUN, 1, 8'h06, 0, 3'b011, 0, WAIT_TILL_EMPTY, 2, 0);
    cyc("wait2b", RUN, 1, 8'h06, 0, 3'b011, 0, WAIT_TILL_EMPTY, 2, 0);
    cyc("wait2c", RUN, 1, 8'h06, 0, 3'b111, 0, WAIT_TILL_EMPTY, 2, 0);
    cyc("lfd2", RUN, 1, 8'h31, 0, 3'b111, 0, LOAD_FIRST_DATA, 2, 0);
    cyc("ld2", RUN, 0, 8'h55, 0, 3'b111, 0, LOAD_DATA, 2, 0);
    cyc("lp2", RUN, 0, 8'h00, 0, 3'b111, 0, LOAD_PARITY, 2, 0);
    cyc("chk2_full", RUN, 0, 8'h00, 3'b100, 3'b111, 0, CHECK_PARITY_ERROR, 2, 0);
    cyc("full2", RUN, 0, 8'h00, 3'b000, 3'b111, 0, FIFO_FULL_STATE, 2, 0);
    cyc("laf2_pd", PD, 0, 8'h00, 0, 3'b111, 0, LOAD_AFTER_FULL, 2, 0);
    cyc("idle2", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 2, 0);
    cyc("hdr0", RUN, 1, 8'h04, 0, 3'b111, 0, DECODE_ADDRESS, 2, 0);
    cyc("lfd0", RUN, 1, 8'h40, 0, 3'b111, 0, LOAD_FIRST_DATA, 0, 0);
    cyc("ld0_other_full", RUN, 1, 8'h41, 3'b110, 3'b111, 0, LOAD_DATA, 0, 0);
    cyc("ld0_full_prio", RUN, 0, 8'h42, 3'b001, 3'b111, 0, LOAD_DATA, 0, 0);
    cyc("full0a", RUN, 0, 8'h42, 3'b001, 3'b111, 0, FIFO_FULL_STATE, 0, 0);
    cyc("full0b", RUN, 0, 8'h42, 3'b000, 3'b111, 0, FIFO_FULL_STATE, 0, 0);
    cyc("laf0_to_ld", RUN, 1, 8'h42, 0, 3'b111, 0, LOAD_AFTER_FULL, 0, 0);
    cyc("ld0c", RUN, 1, 8'h43, 3'b001, 3'b111, 0, LOAD_DATA, 0, 0);
    cyc("full0c", RUN, 0, 8'h43, 3'b000, 3'b111, 0, FIFO_FULL_STATE, 0, 0);
    cyc("laf0_lpv", LPV, 0, 8'h43, 0, 3'b111, 0, LOAD_AFTER_FULL, 0, 0);
    cyc("lp0", RUN, 0, 8'h00, 0, 3'b111, 0, LOAD_PARITY, 0, 0);
    cyc("chk0", RUN, 0, 8'h00, 0, 3'b111, 0, CHECK_PARITY_ERROR, 0, 0);
    cyc("idle0", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("hdr_r", RUN, 1, 8'h05, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("lfd_r", RUN, 1, 8'h50, 0, 3'b111, 0, LOAD_FIRST_DATA, 1, 0);
    cyc("ld_r", RUN, 1, 8'h51, 0, 3'b111, 0, LOAD_DATA, 1, 0);
    cyc("rst_in_ld", RST, 1, 8'h52, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("after_rst", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    cyc("hdr_s", RUN, 1, 8'h05, 0, 3'b111, 0, DECODE_ADDRESS, 0, 0);
    for (int k = 1; k <= 30; k++)
      cyc("sr_count", RUN, 1, 8'h60, 0, 3'b101, 0, k == 1 ? LOAD_FIRST_DATA : LOAD_DATA, 1, 0);
`ifdef ROUTER_SOFT_RST_EN
    cyc("sr_pulse", RUN, 1, 8'h61, 0, 3'b101, 0, LOAD_DATA, 1, 3'b010);
    cyc("sr_abort", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
`else
    cyc("sr_none", RUN, 1, 8'h61, 0, 3'b101, 0, LOAD_DATA, 1, 0);
    cyc("sr_ld_end", RUN, 0, 8'h00, 0, 3'b111, 0, LOAD_DATA, 1, 0);
    cyc("sr_lp", RUN, 0, 8'h00, 0, 3'b111, 0, LOAD_PARITY, 1, 0);
    cyc("sr_chk", RUN, 0, 8'h00, 0, 3'b111, 0, CHECK_PARITY_ERROR, 1, 0);
`endif
    cyc("sr_idle", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
    for (int k = 1; k <= 32; k++)
      cyc("sr_suppress", RUN, 0, 8'h00, 0, 3'b101, k == 30 ? 3'b010 : 3'b000, DECODE_ADDRESS, 1, 0);
    cyc("final", RUN, 0, 8'h00, 0, 3'b111, 0, DECODE_ADDRESS, 1, 0);
    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL count got %0d checks want >= 12", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
